// File: rtl/nfc_ecc_fix.sv
// ECC correction applier: pops decoded error locations and flips the addressed
// bits in the page buffer with a read-modify-write, then reports count/status.
module nfc_ecc_fix #(
  parameter int ECC_AWID   = 12,
  parameter int BUF_AWID   = 12,
  parameter int BUF_DWID   = 8,
  parameter int SECT_BYTES = 512,
  parameter int MAX_ERR    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nfc_ecc_en,
  input  logic                ecc_dec_rdy,
  input  logic [3:0]          ecc_err_num,
  input  logic                ecc_fail,
  input  logic [BUF_AWID-1:0] sect_base,
  output logic                mem_if_rd,
  input  logic [ECC_AWID-1:0] mem_dec_addr,
  output logic                buf_rd,
  output logic                buf_wr,
  output logic [BUF_AWID-1:0] buf_addr,
  output logic [BUF_DWID-1:0] buf_wdat,
  input  logic [BUF_DWID-1:0] buf_rdat,
  output logic                cor_busy,
  output logic                cor_done,
  output logic                cor_fail,
  output logic [3:0]          cor_cnt,
  output logic [3:0]          cor_skip
);

  localparam int OFF_W = ECC_AWID - 3;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] POP  = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]          state_reg, state_next;
  logic [3:0]          rem_reg, rem_next;
  logic [BUF_AWID-1:0] base_reg, base_next;
  logic [BUF_AWID-1:0] addr_reg, addr_next;
  logic [2:0]          bit_reg, bit_next;
  logic [BUF_DWID-1:0] data_reg, data_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [3:0]          skip_reg, skip_next;
  logic                fail_reg, fail_next;

  logic [OFF_W-1:0]    head_off;
  logic                head_oor;
  logic [BUF_AWID-1:0] head_off_ext;
  logic [BUF_DWID-1:0] flip_mask;

  assign head_off = mem_dec_addr[ECC_AWID-1:3];
  assign head_oor = 32'(head_off) >= 32'(SECT_BYTES);

  // Offset is fitted to the buffer address width so the add wraps modulo 2^BUF_AWID.
  generate
    for (genvar gi = 0; gi < BUF_AWID; gi++) begin : g_off_ext
      if (gi < OFF_W) begin : g_bit
        assign head_off_ext[gi] = head_off[gi];
      end else begin : g_zero
        assign head_off_ext[gi] = 1'b0;
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < BUF_DWID; gi++) begin : g_mask
      assign flip_mask[gi] = ({29'd0, bit_reg} == gi);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    base_next  = base_reg;
    addr_next  = addr_reg;
    bit_next   = bit_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    skip_next  = skip_reg;
    fail_next  = fail_reg;
    case (state_reg)
      IDLE: begin
        if (ecc_dec_rdy) begin
          rem_next  = ecc_err_num;
          base_next = sect_base;
          cnt_next  = 4'd0;
          skip_next = 4'd0;
          fail_next = 1'b0;
          if (!nfc_ecc_en || ecc_err_num == 4'd0) begin
            state_next = DONE;
          end else if (ecc_fail || ({28'd0, ecc_err_num} > 32'(MAX_ERR))) begin
            fail_next  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = POP;
          end
        end
      end
      POP: begin
        rem_next = rem_reg - 4'd1;
        if (head_oor) begin
          if (skip_reg != 4'hF) begin
            skip_next = skip_reg + 4'd1;
          end
          state_next = (rem_reg > 4'd1) ? POP : DONE;
        end else begin
          addr_next  = base_reg + head_off_ext;
          bit_next   = mem_dec_addr[2:0];
          state_next = RD;
        end
      end
      RD: begin
        state_next = WAIT;
      end
      WAIT: begin
        data_next  = buf_rdat;
        state_next = WR;
      end
      WR: begin
        cnt_next   = cnt_reg + 4'd1;
        state_next = (rem_reg != 4'd0) ? POP : DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= 4'd0;
      base_reg  <= '0;
      addr_reg  <= '0;
      bit_reg   <= 3'd0;
      data_reg  <= '0;
      cnt_reg   <= 4'd0;
      skip_reg  <= 4'd0;
      fail_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      base_reg  <= base_next;
      addr_reg  <= addr_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      skip_reg  <= skip_next;
      fail_reg  <= fail_next;
    end
  end

  assign mem_if_rd = (state_reg == POP);
  assign buf_rd    = (state_reg == RD);
  assign buf_wr    = (state_reg == WR);
  assign buf_addr  = addr_reg;
  assign buf_wdat  = (state_reg == WR) ? (data_reg ^ flip_mask) : '0;
  assign cor_busy  = (state_reg != IDLE);
  assign cor_done  = (state_reg == DONE);
  assign cor_fail  = fail_reg;
  assign cor_cnt   = cnt_reg;
  assign cor_skip  = skip_reg;

endmodule

// File: tb/tb_nfc_ecc_fix.sv
// Bench for nfc_ecc_fix: buffer/FIFO environment, schedule-based reference model
// checked every cycle, and directed sectors with literal expectations.
module tb_nfc_ecc_fix;

  logic        clk = 1'b0;
  logic        rst;
  logic        nfc_ecc_en;
  logic        ecc_dec_rdy;
  logic [3:0]  ecc_err_num;
  logic        ecc_fail;
  logic [11:0] sect_base;
  logic        mem_if_rd;
  logic [13:0] mem_dec_addr;
  logic        buf_rd;
  logic        buf_wr;
  logic [11:0] buf_addr;
  logic [7:0]  buf_wdat;
  logic [7:0]  buf_rdat = 8'd0;
  logic        cor_busy;
  logic        cor_done;
  logic        cor_fail;
  logic [3:0]  cor_cnt;
  logic [3:0]  cor_skip;

  nfc_ecc_fix #(.ECC_AWID(14)) dut (
    .clk(clk), .rst(rst), .nfc_ecc_en(nfc_ecc_en), .ecc_dec_rdy(ecc_dec_rdy),
    .ecc_err_num(ecc_err_num), .ecc_fail(ecc_fail), .sect_base(sect_base),
    .mem_if_rd(mem_if_rd), .mem_dec_addr(mem_dec_addr), .buf_rd(buf_rd),
    .buf_wr(buf_wr), .buf_addr(buf_addr), .buf_wdat(buf_wdat), .buf_rdat(buf_rdat),
    .cor_busy(cor_busy), .cor_done(cor_done), .cor_fail(cor_fail),
    .cor_cnt(cor_cnt), .cor_skip(cor_skip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_done = 0;
  int start_cyc = 0;

  // Environment: page buffer with registered read, location FIFO.
  logic [7:0]  mem [0:4095];
  logic [13:0] fifo_arr [0:63];
  logic [5:0]  fifo_head = 6'd0;
  logic [5:0]  fifo_tail = 6'd0;
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = 12'd0;
  logic [7:0]  pre_dat = 8'd0;
  logic        flush = 1'b0;

  assign mem_dec_addr = (fifo_head != fifo_tail) ? fifo_arr[fifo_head] : 14'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) mem[pre_addr] <= pre_dat;
    if (buf_wr) mem[buf_addr] <= buf_wdat;
    if (buf_rd) buf_rdat <= mem[buf_addr];
    if (flush) fifo_head <= fifo_tail;
    else if (mem_if_rd && fifo_head != fifo_tail) fifo_head <= fifo_head + 6'd1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, req);
    end
  endtask

  // Reference model: expected per-cycle activity derived from sector parameters.
  logic [7:0] ref_mem [0:4095];
  bit         exp_pop [int];
  int         exp_rd [int];
  int         exp_wa [int];
  int         exp_wd [int];
  int         undo_w [$];
  int         undo_a [$];
  int         undo_old [$];
  bit         sect_active = 1'b0;
  int         done_cyc = -1;
  int         post_rst = -1;
  int         exp_cnt = 0;
  int         exp_skip = 0;
  int         exp_fail = 0;

  task automatic model_accept(input int c);
    int t, n, loc, off, bt, addr;
    logic [7:0] d;
    n = int'(ecc_err_num);
    exp_cnt = 0; exp_skip = 0; exp_fail = 0;
    sect_active = 1'b1;
    undo_w.delete(); undo_a.delete(); undo_old.delete();
    if (!nfc_ecc_en || n == 0) begin
      done_cyc = c + 1;
    end else if (ecc_fail || n > 8) begin
      exp_fail = 1;
      done_cyc = c + 1;
    end else begin
      t = c + 1;
      for (int i = 0; i < n; i++) begin
        loc = int'(fifo_arr[fifo_head + 6'(i)]);
        off = loc / 8;
        bt  = loc % 8;
        exp_pop[t] = 1'b1;
        if (off >= 512) begin
          if (exp_skip < 15) exp_skip++;
          t += 1;
        end else begin
          addr = (int'(sect_base) + off) % 4096;
          exp_rd[t + 1] = addr;
          d = ref_mem[12'(addr)] ^ (8'd1 << bt);
          undo_w.push_back(t + 3); undo_a.push_back(addr); undo_old.push_back(int'(ref_mem[12'(addr)]));
          ref_mem[12'(addr)] = d;
          exp_wa[t + 3] = addr;
          exp_wd[t + 3] = int'(d);
          exp_cnt++;
          t += 4;
        end
      end
      done_cyc = t;
    end
  endtask

  // Single compare process, sampling on the falling edge.
  initial begin
    int c;
    bit busy_e, done_e;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
    forever begin
      @(negedge clk);
      c = cyc;
      busy_e = sect_active && (c <= done_cyc);
      done_e = sect_active && (c == done_cyc);
      chk("mem_if_rd", int'(mem_if_rd), int'(exp_pop.exists(c)));
      chk("buf_rd", int'(buf_rd), int'(exp_rd.exists(c)));
      if (exp_rd.exists(c)) chk("rd_addr", int'(buf_addr), exp_rd[c]);
      chk("buf_wr", int'(buf_wr), int'(exp_wa.exists(c)));
      if (exp_wa.exists(c)) begin
        chk("wr_addr", int'(buf_addr), exp_wa[c]);
        chk("wr_data", int'(buf_wdat), exp_wd[c]);
      end
      chk("cor_busy", int'(cor_busy), int'(busy_e));
      chk("cor_done", int'(cor_done), int'(done_e));
      if (!busy_e || done_e) begin
        chk("cor_cnt", int'(cor_cnt), exp_cnt);
        chk("cor_skip", int'(cor_skip), exp_skip);
        chk("cor_fail", int'(cor_fail), exp_fail);
      end
      if (c == post_rst) begin
        chk("rst_buf_addr", int'(buf_addr), 0);
        chk("rst_buf_wdat", int'(buf_wdat), 0);
      end
      if (cor_done) n_done++;
      if (pre_we) ref_mem[pre_addr] = pre_dat;
      if (rst) begin
        for (int k = undo_w.size() - 1; k >= 0; k--)
          if (undo_w[k] > c) ref_mem[12'(undo_a[k])] = 8'(undo_old[k]);
        undo_w.delete(); undo_a.delete(); undo_old.delete();
        exp_pop.delete(); exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        sect_active = 1'b0;
        exp_cnt = 0; exp_skip = 0; exp_fail = 0;
        post_rst = c + 1;
      end else if (ecc_dec_rdy && !busy_e) begin
        model_accept(c);
      end
    end
  end

  // Stimulus tasks: each starts and ends just after a rising edge.
  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic push(input logic [13:0] v);
    fifo_arr[fifo_tail] = v;
    fifo_tail = fifo_tail + 6'd1;
  endtask

  task automatic start(input logic [3:0] n, input logic f, input logic [11:0] b, input logic en);
    ecc_err_num = n; ecc_fail = f; sect_base = b; nfc_ecc_en = en; ecc_dec_rdy = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    ecc_dec_rdy = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cor_done) begin
        lat = cyc - start_cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, d0;
    rst = 1'b1; nfc_ecc_en = 1'b1; ecc_dec_rdy = 1'b0;
    ecc_err_num = 4'd0; ecc_fail = 1'b0; sect_base = 12'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single flip at 0x203 bit 3
    preload(12'h203, 8'h00);
    push(14'h01B);
    start(4'd1, 1'b0, 12'h200, 1'b1);
    wait_done(lat);
    $display("sector1 lat=%0d cnt=%0d mem203=0x%0h", lat, cor_cnt, mem[12'h203]);
    chk("t1_latency", lat, 5);
    chk("t1_cnt", int'(cor_cnt), 1);
    chk("t1_mem", int'(mem[12'h203]), 8'h08);

    // Duplicate locations cancel
    preload(12'h000, 8'hA5);
    preload(12'h1FF, 8'h00);
    push(14'h000); push(14'h0FFF); push(14'h000);
    start(4'd3, 1'b0, 12'h000, 1'b1);
    wait_done(lat);
    $display("sector2 lat=%0d cnt=%0d mem000=0x%0h mem1ff=0x%0h", lat, cor_cnt, mem[12'h000], mem[12'h1FF]);
    chk("t2_latency", lat, 13);
    chk("t2_cnt", int'(cor_cnt), 3);
    chk("t2_mem000", int'(mem[12'h000]), 8'hA5);
    chk("t2_mem1ff", int'(mem[12'h1FF]), 8'h80);

    // Uncorrectable sector
    start(4'd4, 1'b1, 12'h000, 1'b1);
    wait_done(lat);
    $display("sector3 lat=%0d fail=%0d", lat, cor_fail);
    chk("t3_latency", lat, 1);
    chk("t3_fail", int'(cor_fail), 1);

    // Good sector clears the fail flag
    preload(12'h010, 8'hFF);
    push(14'h080);
    start(4'd1, 1'b0, 12'h000, 1'b1);
    wait_done(lat);
    $display("sector4 lat=%0d fail=%0d mem010=0x%0h", lat, cor_fail, mem[12'h010]);
    chk("t3b_fail", int'(cor_fail), 0);
    chk("t3b_mem", int'(mem[12'h010]), 8'hFE);

    // Both locations out of range
    push(14'h1000); push(14'h2008);
    start(4'd2, 1'b0, 12'h000, 1'b1);
    wait_done(lat);
    $display("sector5 lat=%0d skip=%0d cnt=%0d", lat, cor_skip, cor_cnt);
    chk("t4_latency", lat, 3);
    chk("t4_skip", int'(cor_skip), 2);
    chk("t4_cnt", int'(cor_cnt), 0);

    // Too many locations
    start(4'd9, 1'b0, 12'h000, 1'b1);
    wait_done(lat);
    $display("sector6 lat=%0d fail=%0d", lat, cor_fail);
    chk("tmax_latency", lat, 1);
    chk("tmax_fail", int'(cor_fail), 1);

    // Correction disabled
    start(4'd1, 1'b0, 12'h000, 1'b0);
    wait_done(lat);
    $display("sector7 lat=%0d fail=%0d cnt=%0d", lat, cor_fail, cor_cnt);
    chk("tdis_latency", lat, 1);
    chk("tdis_fail", int'(cor_fail), 0);

    // Address wrap, plus a second ready pulse during WAIT
    preload(12'h001, 8'h3C);
    push(14'h015);
    d0 = n_done;
    start(4'd1, 1'b0, 12'hFFF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ecc_dec_rdy = 1'b1; ecc_err_num = 4'd0; ecc_fail = 1'b1;
    @(posedge clk); #1;
    ecc_dec_rdy = 1'b0; ecc_fail = 1'b0;
    wait_done(lat);
    repeat (4) @(posedge clk);
    #1;
    $display("sector8 lat=%0d dones=%0d mem001=0x%0h", lat, n_done - d0, mem[12'h001]);
    chk("t5_latency", lat, 5);
    chk("t5_done_count", n_done - d0, 1);
    chk("t5_mem001", int'(mem[12'h001]), 8'h1C);

    // Reset during WAIT of a two-location sector
    preload(12'h020, 8'h11);
    preload(12'h021, 8'h22);
    push(14'h100); push(14'h10F);
    d0 = n_done;
    start(4'd2, 1'b0, 12'h000, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("sector9 reset dones=%0d mem020=0x%0h mem021=0x%0h", n_done - d0, mem[12'h020], mem[12'h021]);
    chk("trst_no_done", n_done - d0, 0);
    chk("trst_mem020", int'(mem[12'h020]), 8'h11);
    chk("trst_mem021", int'(mem[12'h021]), 8'h22);

    // Fresh sector after reset
    preload(12'h030, 8'h0F);
    push(14'h181);
    start(4'd1, 1'b0, 12'h000, 1'b1);
    wait_done(lat);
    $display("sector10 lat=%0d cnt=%0d mem030=0x%0h", lat, cor_cnt, mem[12'h030]);
    chk("tfresh_latency", lat, 5);
    chk("tfresh_cnt", int'(cor_cnt), 1);
    chk("tfresh_mem", int'(mem[12'h030]), 8'h0D);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
